// File: rtl/ibex_xif_rf_pkg.sv
// Shared types and sizes for the XIF multi-port register file.
package ibex_xif_rf_pkg;

   localparam int unsigned RegAddrW      = 5;
   localparam int unsigned NumWordsRV32I = 32;
   localparam int unsigned NumWordsRV32E = 16;

   typedef logic [RegAddrW-1:0] rf_addr_t;

   typedef enum logic {
      WP_CORE = 1'b0,
      WP_XIF  = 1'b1
   } rf_wport_e;

   // Number of architectural registers for the selected base ISA.
   function automatic int unsigned num_words(input bit rv32e);
      return rv32e ? NumWordsRV32E : NumWordsRV32I;
   endfunction

endpackage

// File: rtl/ibex_xif_register_file_mp_if.sv
// Request/response bundle between the ID stage and the XIF register file.
interface ibex_xif_register_file_mp_if #(
   parameter int unsigned NumReadPorts = 2,
   parameter int unsigned DataWidth    = 32,
   parameter int unsigned IdWidth      = 4
) ();
   import ibex_xif_rf_pkg::*;

   rf_addr_t [NumReadPorts-1:0]                 raddr_i;
   logic     [NumReadPorts-1:0][DataWidth-1:0]  rdata_o;
   logic     [NumReadPorts-1:0]                 rpending_o;

   logic                  we_core_i;
   rf_addr_t              waddr_core_i;
   logic [DataWidth-1:0]  wdata_core_i;

   logic                  rsv_valid_i;
   rf_addr_t              rsv_addr_i;
   logic [IdWidth-1:0]    rsv_id_i;

   logic                  we_xif_i;
   rf_addr_t              waddr_xif_i;
   logic [IdWidth-1:0]    wid_xif_i;
   logic [DataWidth-1:0]  wdata_xif_i;

   logic                  flush_i;
   logic                  err_o;

   modport master (
      output raddr_i, we_core_i, waddr_core_i, wdata_core_i,
             rsv_valid_i, rsv_addr_i, rsv_id_i,
             we_xif_i, waddr_xif_i, wid_xif_i, wdata_xif_i, flush_i,
      input  rdata_o, rpending_o, err_o
   );

   modport slave (
      input  raddr_i, we_core_i, waddr_core_i, wdata_core_i,
             rsv_valid_i, rsv_addr_i, rsv_id_i,
             we_xif_i, waddr_xif_i, wid_xif_i, wdata_xif_i, flush_i,
      output rdata_o, rpending_o, err_o
   );

endinterface

// File: rtl/ibex_xif_rf_scoreboard.sv
// Pending/ID scoreboard for offloaded instructions awaiting an rd result.
module ibex_xif_rf_scoreboard #(
   parameter int unsigned NumWords = 32,
   parameter int unsigned AddrW    = 5,
   parameter int unsigned IdWidth  = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                rsv_valid_i,
   input  logic [AddrW-1:0]    rsv_idx_i,
   input  logic [IdWidth-1:0]  rsv_id_i,
   input  logic                we_xif_i,
   input  logic [AddrW-1:0]    xif_idx_i,
   input  logic [IdWidth-1:0]  wid_xif_i,
   input  logic                flush_i,
   output logic [NumWords-1:0] pend_o,
   output logic                xif_accept_o,
   output logic                err_o
);

   logic [NumWords-1:0]              pend_q, pend_d;
   logic [NumWords-1:0][IdWidth-1:0] id_q, id_d;

   // A result is accepted only by the instruction that currently owns rd.
   assign xif_accept_o = we_xif_i & pend_q[xif_idx_i] & (id_q[xif_idx_i] == wid_xif_i);
   assign err_o        = we_xif_i & ~xif_accept_o;
   assign pend_o       = pend_q;

   // Clear, then flush, then reserve: a reserve beats a same-cycle clear but not a flush.
   always_comb begin
      pend_d = pend_q;
      id_d   = id_q;
      if (xif_accept_o) begin
         pend_d[xif_idx_i] = 1'b0;
      end
      if (flush_i) begin
         pend_d = '0;
      end else if (rsv_valid_i && (rsv_idx_i != '0)) begin
         pend_d[rsv_idx_i] = 1'b1;
         id_d[rsv_idx_i]   = rsv_id_i;
      end
      pend_d[0] = 1'b0;
   end

   // Scoreboard state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
         id_q   <= '0;
      end else begin
         pend_q <= pend_d;
         id_q   <= id_d;
      end
   end

endmodule

// File: rtl/ibex_xif_register_file_mp.sv
// Flop-based register file with N read ports, core + coprocessor write ports
// and a pending scoreboard. Define IBEX_XIF_RF_FORWARD_EN to forward
// same-cycle accepted writes to the read ports.
module ibex_xif_register_file_mp
   import ibex_xif_rf_pkg::*;
#(
   parameter bit                    RV32E        = 1'b0,
   parameter int unsigned           DataWidth    = 32,
   parameter int unsigned           NumReadPorts = 2,
   parameter int unsigned           IdWidth      = 4,
   parameter logic [DataWidth-1:0]  WordZeroVal  = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   ibex_xif_register_file_mp_if.slave   rf_if
);

   localparam int unsigned NumWords = num_words(RV32E);
   localparam int unsigned AddrW    = RV32E ? 4 : 5;

   typedef logic [AddrW-1:0] idx_t;

   idx_t core_idx, xif_idx, rsv_idx;
   logic [NumWords-1:0] pend;
   logic                xif_accept;

   logic [NumWords-1:0][DataWidth-1:0]     mem_q, mem_d;
   logic [NumReadPorts-1:0][DataWidth-1:0] rdata;
   logic [NumReadPorts-1:0]                rpending;

   // In RV32E the upper address bit is ignored.
   assign core_idx = rf_if.waddr_core_i[AddrW-1:0];
   assign xif_idx  = rf_if.waddr_xif_i[AddrW-1:0];
   assign rsv_idx  = rf_if.rsv_addr_i[AddrW-1:0];

   ibex_xif_rf_scoreboard #(
      .NumWords (NumWords),
      .AddrW    (AddrW),
      .IdWidth  (IdWidth)
   ) u_scoreboard (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rsv_valid_i  (rf_if.rsv_valid_i),
      .rsv_idx_i    (rsv_idx),
      .rsv_id_i     (rf_if.rsv_id_i),
      .we_xif_i     (rf_if.we_xif_i),
      .xif_idx_i    (xif_idx),
      .wid_xif_i    (rf_if.wid_xif_i),
      .flush_i      (rf_if.flush_i),
      .pend_o       (pend),
      .xif_accept_o (xif_accept),
      .err_o        (rf_if.err_o)
   );

   // Write arbitration: an accepted XIF result overrides a core write to the same register.
   always_comb begin
      mem_d = mem_q;
      if (rf_if.we_core_i && (core_idx != '0)) begin
         mem_d[core_idx] = rf_if.wdata_core_i;
      end
      if (xif_accept) begin
         mem_d[xif_idx] = rf_if.wdata_xif_i;
      end
      mem_d[0] = WordZeroVal;
   end

   // Register storage; x0 is held at its constant value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q <= {NumWords{WordZeroVal}};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Read ports, optionally bypassing same-cycle accepted writes.
   always_comb begin
      idx_t ridx;
      ridx     = '0;
      rdata    = '0;
      rpending = '0;
      for (int unsigned k = 0; k < NumReadPorts; k++) begin
         ridx        = rf_if.raddr_i[k][AddrW-1:0];
         rdata[k]    = mem_q[ridx];
         rpending[k] = pend[ridx];
`ifdef IBEX_XIF_RF_FORWARD_EN
         if (xif_accept && (xif_idx == ridx)) begin
            rdata[k] = rf_if.wdata_xif_i;
            if (!(rf_if.rsv_valid_i && (rsv_idx == ridx))) begin
               rpending[k] = 1'b0;
            end
         end else if (rf_if.we_core_i && (core_idx == ridx) && (ridx != '0)) begin
            rdata[k] = rf_if.wdata_core_i;
         end
`endif
      end
   end

   assign rf_if.rdata_o    = rdata;
   assign rf_if.rpending_o = rpending;

endmodule
